sp_ram_param: RTL and testbench
===============================

// Module: sp_ram_param
// PURPOSE
//  Parametrised single-port synchronous RAM; successor to the fixed 8x64 asynchronous-read RAM.
//  Adds synchronous read, optional output register, byte-enable writes and selectable
//  read-during-write mode. A reset-driven clear FSM zeroes the array, with a busy flag.
//  General scratch/buffer memory for datapath blocks in this design.
// PARAMETERS
//  DATA_W         32  word width in bits; must be a multiple of BYTE_W
//  ADDR_W         6   address width; DEPTH = 2**ADDR_W words
//  BYTE_W         8   byte-lane width; NB = DATA_W/BYTE_W lanes
//  WRITE_MODE     0   read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
//  OUT_REG        0   1 = extra output pipeline register (read latency 2 instead of 1)
//  CLEAR_ON_RESET 1   1 = zero every word after reset; 0 = contents untouched by reset
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous active-high reset
//  en         in   1       access enable; no access when low
//  we         in   1       write when en=1; read when en=1 and we=0
//  be         in   NB      byte-lane write enables; lane i = din[i*BYTE_W +: BYTE_W]
//  addr       in   ADDR_W  word address
//  din        in   DATA_W  write data
//  dout       out  DATA_W  read data
//  dout_valid out  1       one-cycle pulse: dout updated by an access this cycle
//  busy       out  1       clear in progress; accesses ignored while high
// BEHAVIOUR
//  Reset (rst=1 on a clock edge): dout=0, dout_valid=0, OUT_REG pipeline stage and valid cleared.
//   clr_addr=0; state=CLEAR and busy=1 if CLEAR_ON_RESET, else state=IDLE and busy=0.
//  FSM states: IDLE, CLEAR.
//   CLEAR: each cycle mem[clr_addr]<=0, clr_addr++. At clr_addr=DEPTH-1, go to IDLE.
//   busy is registered: high during rst and for exactly DEPTH cycles after rst falls.
//   IDLE: services accesses. rst in any state restarts from reset values and clr_addr=0.
//  Access = en & ~busy, sampled at edge T. en/we/be/addr/din ignored while busy (no write, no valid).
//  Write (we=1): for each lane i with be[i]=1, mem[addr] lane i <= din lane i. Other lanes keep old data.
//   be=0 leaves the array unchanged but is still an access for the read-out rules.
//  Read-out per access (base latency: data visible after edge T):
//   read (we=0): dout <= mem[addr] (old contents), dout_valid=1.
//   write, READ_FIRST: dout <= pre-write word, dout_valid=1.
//   write, WRITE_FIRST: dout <= merged post-write word, dout_valid=1.
//   write, NO_CHANGE: dout holds, dout_valid=0.
//  OUT_REG=1: dout and dout_valid pass through one more register (visible after edge T+1).
//   Back-to-back accesses stream one per cycle; there is no stall.
//  dout holds its last value when no access occurs. dout_valid is 0 on all non-access cycles.
//  Address is a plain index: all 2**ADDR_W words are valid, with no range check or wrap logic.
//  Back-to-back write then read of the same address returns the written data (no hazard).
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=64: pulse rst 1 cycle.
//    -> busy high 64 cycles after rst falls. Reads of addr 0, 37, 63 then return 0 with dout_valid.
//  2 Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101.
//    -> read addr 5 returns 0xDE22BE44, one cycle after the read (OUT_REG=0).
//  3 Preload addr 9=0xAAAAAAAA, write 0x55555555 to addr 9 (be=4'hF).
//    -> READ_FIRST: dout=0xAAAAAAAA, valid=1. WRITE_FIRST: dout=0x55555555, valid=1.
//       NO_CHANGE: dout unchanged, valid=0.
//  4 OUT_REG=1, read addrs 1,2,3 on consecutive cycles.
//    -> data appears 2 cycles after each read, on 3 consecutive valid pulses.
//  5 Assert rst when clr_addr=20, release 1 cycle later.
//    -> clear restarts at 0, busy high 64 cycles. Writes attempted while busy do not land.

Source files
------------

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a reset-triggered clear sequencer.
module sp_ram_param #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [DATA_W/BYTE_W-1:0] i_be,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout,
  output logic                     o_dout_valid,
  output logic                     o_busy
);

  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              w_clr_we;

  logic              w_access;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] r_dout1;
  logic              r_valid1;

  // Clear sequencer state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      r_clr_addr <= '0;
      r_busy     <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Clear sequencer next state: one word zeroed per cycle, busy drops with the last word
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_busy_nxt     = r_busy;
    w_clr_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt    = ST_IDLE;
          w_clr_addr_nxt = '0;
          w_busy_nxt     = 1'b0;
        end else begin
          w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
          w_busy_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_access  = i_en & ~r_busy & ~i_rst;
  assign w_rd_word = r_mem[i_addr];

  // Post-write word, used for WRITE_FIRST read-out
  always_comb begin
    w_merged = w_rd_word;
    for (int i = 0; i < int'(NB); i++) begin
      if (i_be[i]) w_merged[i*BYTE_W +: BYTE_W] = i_din[i*BYTE_W +: BYTE_W];
    end
  end

  // Array write port, shared between the clear sequencer and user writes
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (w_clr_we) begin
        r_mem[r_clr_addr] <= '0;
      end else if (w_access && i_we) begin
        for (int i = 0; i < int'(NB); i++) begin
          if (i_be[i]) r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_din[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // First read-out stage; NO_CHANGE writes leave the data untouched and raise no valid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= 1'b0;
      if (w_access) begin
        if (!i_we) begin
          r_dout1  <= w_rd_word;
          r_valid1 <= 1'b1;
        end else if (WRITE_MODE == 1) begin
          r_dout1  <= w_merged;
          r_valid1 <= 1'b1;
        end else if (WRITE_MODE != 2) begin
          r_dout1  <= w_rd_word;
          r_valid1 <= 1'b1;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_dout2;
      logic              r_valid2;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_dout2  <= '0;
          r_valid2 <= 1'b0;
        end else begin
          r_dout2  <= r_dout1;
          r_valid2 <= r_valid1;
        end
      end

      assign o_dout       = r_dout2;
      assign o_dout_valid = r_valid2;
    end else begin : g_no_out_reg
      assign o_dout       = r_dout1;
      assign o_dout_valid = r_valid1;
    end
  endgenerate

  assign o_busy = r_busy;

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: four instances (READ_FIRST, WRITE_FIRST, NO_CHANGE, READ_FIRST with
// output register) share one stimulus stream and are checked against hand-computed values.
module tb_sp_ram_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  be;
  logic [5:0]  addr;
  logic [31:0] din;

  logic [31:0] dout_rf, dout_wf, dout_nc, dout_or;
  logic        v_rf, v_wf, v_nc, v_or;
  logic        busy_rf, busy_wf, busy_nc, busy_or;

  int errors = 0;
  int checks = 0;

  sp_ram_param #(.WRITE_MODE(0), .OUT_REG(0)) dut_rf (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr), .i_din(din),
    .o_dout(dout_rf), .o_dout_valid(v_rf), .o_busy(busy_rf));
  sp_ram_param #(.WRITE_MODE(1), .OUT_REG(0)) dut_wf (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr), .i_din(din),
    .o_dout(dout_wf), .o_dout_valid(v_wf), .o_busy(busy_wf));
  sp_ram_param #(.WRITE_MODE(2), .OUT_REG(0)) dut_nc (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr), .i_din(din),
    .o_dout(dout_nc), .o_dout_valid(v_nc), .o_busy(busy_nc));
  sp_ram_param #(.WRITE_MODE(0), .OUT_REG(1)) dut_or (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_we(we), .i_be(be), .i_addr(addr), .i_din(din),
    .o_dout(dout_or), .o_dout_valid(v_or), .o_busy(busy_or));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        we;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] din;
    logic [31:0] e_rf;
    logic [31:0] e_wf;
    logic [31:0] e_nc;
    logic        e_v;
    logic        e_vnc;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic acc(input logic e, input logic w, input logic [3:0] b, input logic [5:0] a,
                     input logic [31:0] d);
    en = e; we = w; be = b; addr = a; din = d;
  endtask

  initial begin
    int          cnt;
    logic        saw_valid;
    logic [31:0] prev_d;
    logic        prev_v;

    // en, we, be, addr, din, rf, wf, nc, valid, valid(nc)
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 6'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 6'd37, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 4'h0, 6'd63, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 4'hF, 6'd5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'h5, 6'd5,  32'h11223344, 32'hDEADBEEF, 32'hDE22BE44, 32'h0,        1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 6'd5,  32'h0,        32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 6'd5,  32'h0,        32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 6'd9,  32'hAAAAAAAA, 32'h0,        32'hAAAAAAAA, 32'hDE22BE44, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'hF, 6'd9,  32'h55555555, 32'hAAAAAAAA, 32'h55555555, 32'hDE22BE44, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 6'd9,  32'h0,        32'h55555555, 32'h55555555, 32'h55555555, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 4'h0, 6'd12, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h55555555, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 6'd12, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'hF, 6'd63, 32'h01020304, 32'h0,        32'h01020304, 32'h0,        1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 6'd63, 32'h0,        32'h01020304, 32'h01020304, 32'h01020304, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b1, 4'hF, 6'd63, 32'hFFFFFFFF, 32'h01020304, 32'h01020304, 32'h01020304, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'h0, 6'd63, 32'h0,        32'h01020304, 32'h01020304, 32'h01020304, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 4'h0, 6'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b1};

    rst = 1'b1;
    acc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    chk("reset dout", dout_rf, 32'h0);
    chk("reset valid", 32'(v_rf), 32'h0);
    chk("reset busy", 32'(busy_rf), 32'h1);
    chk("reset dout_or", dout_or, 32'h0);
    chk("reset valid_or", 32'(v_or), 32'h0);
    rst = 1'b0;

    // Busy must stay high for exactly 64 cycles after reset releases
    cnt = 0;
    while (busy_rf && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("busy cycles", 32'(cnt), 32'd64);

    prev_d = 32'h0;
    prev_v = 1'b0;
    for (int i = 0; i < NV; i++) begin
      acc(vecs[i].en, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].din);
      tick();
      chk($sformatf("v%0d rf dout", i), dout_rf, vecs[i].e_rf);
      chk($sformatf("v%0d rf valid", i), 32'(v_rf), 32'(vecs[i].e_v));
      chk($sformatf("v%0d wf dout", i), dout_wf, vecs[i].e_wf);
      chk($sformatf("v%0d wf valid", i), 32'(v_wf), 32'(vecs[i].e_v));
      chk($sformatf("v%0d nc dout", i), dout_nc, vecs[i].e_nc);
      chk($sformatf("v%0d nc valid", i), 32'(v_nc), 32'(vecs[i].e_vnc));
      chk($sformatf("v%0d or dout", i), dout_or, prev_d);
      chk($sformatf("v%0d or valid", i), 32'(v_or), 32'(prev_v));
      prev_d = vecs[i].e_rf;
      prev_v = vecs[i].e_v;
    end

    // Streaming reads through the output register
    acc(1'b1, 1'b1, 4'hF, 6'd1, 32'h00000111); tick();
    acc(1'b1, 1'b1, 4'hF, 6'd2, 32'h00000222); tick();
    acc(1'b1, 1'b1, 4'hF, 6'd3, 32'h00000333); tick();
    acc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);        tick();
    acc(1'b1, 1'b0, 4'h0, 6'd1, 32'h0);        tick();
    chk("stream r1 or valid", 32'(v_or), 32'h0);
    chk("stream r1 rf dout", dout_rf, 32'h00000111);
    acc(1'b1, 1'b0, 4'h0, 6'd2, 32'h0);        tick();
    chk("stream r2 or dout", dout_or, 32'h00000111);
    chk("stream r2 or valid", 32'(v_or), 32'h1);
    chk("stream r2 rf dout", dout_rf, 32'h00000222);
    acc(1'b1, 1'b0, 4'h0, 6'd3, 32'h0);        tick();
    chk("stream r3 or dout", dout_or, 32'h00000222);
    chk("stream r3 or valid", 32'(v_or), 32'h1);
    acc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);        tick();
    chk("stream idle1 or dout", dout_or, 32'h00000333);
    chk("stream idle1 or valid", 32'(v_or), 32'h1);
    chk("stream idle1 rf valid", 32'(v_rf), 32'h0);
    tick();
    chk("stream idle2 or dout", dout_or, 32'h00000333);
    chk("stream idle2 or valid", 32'(v_or), 32'h0);

    // Reset in the middle of a clear restarts it from address 0
    acc(1'b1, 1'b1, 4'hF, 6'd30, 32'h12345678); tick();
    acc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (20) tick();
    chk("mid-clear busy", 32'(busy_rf), 32'h1);
    rst = 1'b1; tick();
    chk("re-reset busy", 32'(busy_rf), 32'h1);
    chk("re-reset dout", dout_rf, 32'h0);
    rst = 1'b0;
    acc(1'b1, 1'b1, 4'hF, 6'd2, 32'hBADBAD00);
    cnt = 0;
    saw_valid = 1'b0;
    while (busy_rf && cnt < 200) begin
      cnt++;
      tick();
      saw_valid = saw_valid | v_rf | v_wf | v_or;
    end
    chk("restart busy cycles", 32'(cnt), 32'd64);
    chk("valid while busy", 32'(saw_valid), 32'h0);
    acc(1'b1, 1'b0, 4'h0, 6'd2, 32'h0); tick();
    chk("busy write blocked", dout_rf, 32'h0);
    chk("busy write blocked valid", 32'(v_rf), 32'h1);
    acc(1'b1, 1'b0, 4'h0, 6'd30, 32'h0); tick();
    chk("cleared addr 30", dout_rf, 32'h0);
    acc(1'b1, 1'b0, 4'h0, 6'd3, 32'h0); tick();
    chk("cleared addr 3", dout_wf, 32'h0);
    acc(1'b0, 1'b0, 4'h0, 6'd0, 32'h0); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
